sargantana_icache_flush_ctrl: RTL and testbench

SARGANTANA_ICACHE_FLUSH_CTRL -- requirements
Module: sargantana_icache_flush_ctrl

---
 rtl/sargantana_icache_flush_ctrl.sv | 100 ++++++++++
 tb/tb_sargantana_icache_flush_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sargantana_icache_flush_ctrl.sv
// Instruction-cache flush controller: drains refills, walks the cleaner over every set
// and pulses an ack. Macro ICACHE_FLUSH_ON_RESET_EN makes reset start with a full walk.
module sargantana_icache_flush_ctrl #(
    parameter int unsigned ADDR_WIDHT   = 6,
    parameter int unsigned ICACHE_DEPTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_req_i,
    output logic                  flush_ack_o,
    input  logic                  refill_busy_i,
    output logic                  lookup_ready_o,
    output logic                  clean_en_o,
    input  logic                  clean_done_i,
    input  logic [ADDR_WIDHT-1:0] clean_addr_i,
    output logic                  vbit_we_o,
    output logic [ADDR_WIDHT-1:0] vbit_addr_o,
    output logic                  vbit_data_o,
    output logic [15:0]           flush_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAN = 2'd2,
        DONE  = 2'd3
    } state_t;

`ifdef ICACHE_FLUSH_ON_RESET_EN
    localparam state_t RESET_STATE = CLEAN;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    // The cleaner's index width fixes the number of sets it walks.
    if (ICACHE_DEPTH != (1 << ADDR_WIDHT)) begin : g_depth_check
        $error("ICACHE_DEPTH must equal 2**ADDR_WIDHT");
    end

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= RESET_STATE;
            pending_q   <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (state_q == DONE && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        lookup_ready_o = 1'b0;
        clean_en_o     = 1'b0;
        vbit_we_o      = 1'b0;
        flush_ack_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                lookup_ready_o = !flush_req_i;
                if (flush_req_i) begin
                    state_d = refill_busy_i ? DRAIN : CLEAN;
                end
            end
            DRAIN: begin
                if (flush_req_i) pending_d = 1'b1;
                if (!refill_busy_i) state_d = CLEAN;
            end
            CLEAN: begin
                clean_en_o = 1'b1;
                vbit_we_o  = 1'b1;
                if (flush_req_i) pending_d = 1'b1;
                if (clean_done_i) state_d = DONE;
            end
            DONE: begin
                flush_ack_o = 1'b1;
                // A request landing in DONE is folded straight into the next walk.
                if (pending_q || flush_req_i) begin
                    state_d   = CLEAN;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign vbit_addr_o = clean_addr_i;
    assign vbit_data_o = 1'b0;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_sargantana_icache_flush_ctrl.sv
// Randomized bench for sargantana_icache_flush_ctrl against a cycle-count reference model;
// includes a stand-in for the set cleaner.
module tb_sargantana_icache_flush_ctrl;

    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush_req = 1'b0;
    logic          refill_busy = 1'b0;
    logic          flush_ack, lookup_ready, clean_en, vbit_we, vbit_data;
    logic [AW-1:0] clean_addr, vbit_addr;
    logic          clean_done;
    logic [15:0]   flush_cnt;

    always #5 clk = ~clk;

    sargantana_icache_flush_ctrl #(
        .ADDR_WIDHT  (AW),
        .ICACHE_DEPTH(DEPTH)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .flush_req_i   (flush_req),
        .flush_ack_o   (flush_ack),
        .refill_busy_i (refill_busy),
        .lookup_ready_o(lookup_ready),
        .clean_en_o    (clean_en),
        .clean_done_i  (clean_done),
        .clean_addr_i  (clean_addr),
        .vbit_we_o     (vbit_we),
        .vbit_addr_o   (vbit_addr),
        .vbit_data_o   (vbit_data),
        .flush_cnt_o   (flush_cnt)
    );

    // Cleaner stand-in: index advances while enabled, wraps, shares the reset.
    always_ff @(posedge clk) begin
        if (!rstn)         clean_addr <= '0;
        else if (clean_en) clean_addr <= clean_addr + 1'b1;
    end
    assign clean_done = (clean_addr == AW'(DEPTH - 1));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sets left to invalidate, drain flag, ack-this-cycle flag.
    bit model_valid = 1'b0;
    int clean_left  = 0;
    bit draining    = 1'b0;
    bit ack_now     = 1'b0;
    bit pend        = 1'b0;
    int flushes     = 0;
    int we_seen     = 0;
    int acks_seen   = 0;

    function automatic bit model_idle();
        return clean_left == 0 && !draining && !ack_now;
    endfunction

    task automatic model_update(input bit r, input bit b, input bit rn);
        if (!rn) begin
`ifdef ICACHE_FLUSH_ON_RESET_EN
            clean_left = DEPTH;
`else
            clean_left = 0;
`endif
            draining = 0; ack_now = 0; pend = 0; flushes = 0;
            model_valid = 1'b1;
        end else if (model_idle()) begin
            if (r) begin
                if (b) draining = 1;
                else   clean_left = DEPTH;
            end
        end else if (draining) begin
            if (r) pend = 1;
            if (!b) begin
                draining = 0;
                clean_left = DEPTH;
            end
        end else if (clean_left > 0) begin
            if (r) pend = 1;
            clean_left--;
            if (clean_left == 0) ack_now = 1;
        end else begin
            ack_now = 0;
            flushes = (flushes >= 16'hFFFF) ? 16'hFFFF : flushes + 1;
            if (pend || r) begin
                clean_left = DEPTH;
                pend = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit b, input bit rn);
        @(negedge clk);
        flush_req = r; refill_busy = b; rstn = rn;
        #1;
        if (model_valid) begin
            check_eq("vbit_we", {31'd0, vbit_we}, {31'd0, clean_left > 0});
            check_eq("clean_en", {31'd0, clean_en}, {31'd0, clean_left > 0});
            check_eq("flush_ack", {31'd0, flush_ack}, {31'd0, ack_now});
            check_eq("lookup_ready", {31'd0, lookup_ready}, {31'd0, model_idle() && !r});
            check_eq("flush_cnt", {16'd0, flush_cnt}, flushes);
            check_eq("vbit_data", {31'd0, vbit_data}, 32'd0);
            if (clean_left > 0)
                check_eq("vbit_addr", {26'd0, vbit_addr}, DEPTH - clean_left);
        end
        if (vbit_we === 1'b1)   we_seen++;
        if (flush_ack === 1'b1) acks_seen++;
        @(posedge clk);
        model_update(r, b, rn);
    endtask

    initial begin
        bit busy_r = 0;
        repeat (2) step(0, 0, 0);
        repeat (80) step(0, 0, 1);

        // Basic flush: 64 writes then one ack.
        we_seen = 0; acks_seen = 0;
        step(1, 0, 1);
        repeat (70) step(0, 0, 1);
        check_eq("basic_walk_len", we_seen, 64);
        check_eq("basic_acks", acks_seen, 1);

        // Drain: refill busy for five cycles holds off the walk.
        we_seen = 0;
        step(1, 1, 1);
        repeat (4) step(0, 1, 1);
        check_eq("drain_no_we", we_seen, 0);
        repeat (70) step(0, 0, 1);
        check_eq("drain_walk_len", we_seen, 64);

        // Coalescing: three requests mid-walk yield a single extra walk.
        we_seen = 0; acks_seen = 0;
        step(1, 0, 1);
        repeat (3) begin
            repeat (10) step(0, 0, 1);
            step(1, 0, 1);
        end
        repeat (140) step(0, 0, 1);
        check_eq("coalesce_acks", acks_seen, 2);
        check_eq("coalesce_walk_len", we_seen, 128);

        // Reset mid-walk aborts without ack; the next walk restarts at set 0.
        acks_seen = 0;
        step(1, 0, 1);
        repeat (30) step(0, 0, 1);
        step(0, 0, 0);
        check_eq("abort_no_ack", acks_seen, 0);
        repeat (80) step(0, 0, 1);
        we_seen = 0;
        step(1, 0, 1);
        repeat (70) step(0, 0, 1);
        check_eq("rewalk_len", we_seen, 64);

        // Saturation from a preloaded count.
        @(negedge clk);
        force dut.flush_cnt_q = 16'hFFFE;
        #1 release dut.flush_cnt_q;
        flushes = 16'hFFFE;
        repeat (2) begin
            step(1, 0, 1);
            repeat (70) step(0, 0, 1);
        end
        check_eq("saturated_cnt", {16'd0, flush_cnt}, 32'h0000FFFF);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) busy_r = ~busy_r;
            step($urandom_range(0, 29) == 0, busy_r, $urandom_range(0, 1999) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
